// File: rtl/booth_seq_divider_pkg.sv
// booth_seq_divider_pkg
//   Shared arithmetic definitions for the Booth multiplier / sequential
//   divider pair: default operand widths, divider FSM state encoding, and
//   small two's-complement helpers used for sign handling.
package booth_seq_divider_pkg;

  localparam int DEF_DW = 8;  // product / dividend / quotient width
  localparam int DEF_VW = 4;  // multiplicand / divisor / remainder width

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } div_state_e;

  // Magnitude of a DEF_DW-bit signed value, one bit wider so that
  // -2^(DEF_DW-1) has an exact representation.
  function automatic logic [DEF_DW:0] abs_dw(input logic [DEF_DW-1:0] v);
    logic [DEF_DW:0] ext;
    ext = {v[DEF_DW-1], v};
    return ext[DEF_DW] ? (~ext + 1'b1) : ext;
  endfunction

  // Magnitude of a DEF_VW-bit signed value, one bit wider for the same reason.
  function automatic logic [DEF_VW:0] abs_vw(input logic [DEF_VW-1:0] v);
    logic [DEF_VW:0] ext;
    ext = {v[DEF_VW-1], v};
    return ext[DEF_VW] ? (~ext + 1'b1) : ext;
  endfunction

  // Conditional two's-complement negation at product width.
  function automatic logic [DEF_DW-1:0] neg_dw(input logic neg, input logic [DEF_DW-1:0] v);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/booth_div_step.sv
// booth_div_step
//   One combinational restoring-division step: shift the next dividend bit
//   into the partial remainder, trial-subtract the divisor magnitude, and
//   keep the difference only when it is non-negative.
// Ports:
//   partial_rem  in   VW+1  partial remainder before this step
//   next_bit     in   1     dividend bit shifted in
//   div_mag      in   VW    divisor magnitude (unsigned, up to 2^(VW-1))
//   new_rem      out  VW+1  partial remainder after this step
//   q_bit        out  1     quotient bit produced by this step
module booth_div_step #(
  parameter int VW = 4
) (
  input  logic [VW:0]   partial_rem,
  input  logic          next_bit,
  input  logic [VW-1:0] div_mag,
  output logic [VW:0]   new_rem,
  output logic          q_bit
);

  // One guard bit above the shifted value so the trial result's MSB is a
  // clean borrow/sign indicator.
  logic [VW+1:0] shifted;
  logic [VW+1:0] trial;

  always_comb begin
    shifted = {partial_rem, next_bit};
    trial   = shifted - {2'b00, div_mag};
    q_bit   = ~trial[VW+1];
    new_rem = q_bit ? trial[VW:0] : shifted[VW:0];
  end

endmodule

// File: rtl/booth_seq_divider.sv
// booth_seq_divider
//   Sequential signed divider, one quotient bit per clock, restoring
//   algorithm on operand magnitudes with signs applied at the end.
//   Quotient truncates toward zero; remainder takes the dividend's sign.
// Ports:
//   clk, rst_n          clock (rising edge) / asynchronous active-low reset
//   start               request, sampled only when idle
//   dividend, divisor   signed operands, sampled with start
//   busy                high while an operation is in progress
//   done                one-cycle pulse when results are valid
//   quotient, remainder signed results, held until next done or reset
//   div_zero, ovf       divisor was zero / quotient not representable
module booth_seq_divider
  import booth_seq_divider_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int VW = DEF_VW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_zero,
  output logic          ovf
);

  localparam int CW = $clog2(DW + 1);

  div_state_e    state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [VW:0]   prem_reg, prem_next;
  // Holds the dividend magnitude; quotient bits shift in from the LSB as
  // dividend bits leave from the MSB, so it ends up holding |quotient|.
  logic [DW-1:0] dq_reg, dq_next;
  logic [VW-1:0] vmag_reg, vmag_next;
  logic          sign_q_reg, sign_q_next;
  logic          sign_r_reg, sign_r_next;
  logic          dz_reg, dz_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;
  logic [DW-1:0] quotient_reg, quotient_next;
  logic [VW-1:0] remainder_reg, remainder_next;
  logic          div_zero_reg, div_zero_next;
  logic          ovf_reg, ovf_next;

  logic [VW:0]   step_rem;
  logic          step_q;
  // Magnitudes as unsigned values of the operand width: |-2^(W-1)| = 2^(W-1)
  // still fits, which is what makes -128/2 exact and -128/-1 detectable.
  logic [DW-1:0] dividend_mag;
  logic [VW-1:0] divisor_mag;

  assign dividend_mag = dividend[DW-1] ? (~dividend + 1'b1) : dividend;
  assign divisor_mag  = divisor[VW-1]  ? (~divisor + 1'b1)  : divisor;

  booth_div_step #(.VW(VW)) u_step (
    .partial_rem (prem_reg),
    .next_bit    (dq_reg[DW-1]),
    .div_mag     (vmag_reg),
    .new_rem     (step_rem),
    .q_bit       (step_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      prem_reg      <= '0;
      dq_reg        <= '0;
      vmag_reg      <= '0;
      sign_q_reg    <= 1'b0;
      sign_r_reg    <= 1'b0;
      dz_reg        <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      div_zero_reg  <= 1'b0;
      ovf_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      prem_reg      <= prem_next;
      dq_reg        <= dq_next;
      vmag_reg      <= vmag_next;
      sign_q_reg    <= sign_q_next;
      sign_r_reg    <= sign_r_next;
      dz_reg        <= dz_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      quotient_reg  <= quotient_next;
      remainder_reg <= remainder_next;
      div_zero_reg  <= div_zero_next;
      ovf_reg       <= ovf_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    prem_next      = prem_reg;
    dq_next        = dq_reg;
    vmag_next      = vmag_reg;
    sign_q_next    = sign_q_reg;
    sign_r_next    = sign_r_reg;
    dz_next        = dz_reg;
    busy_next      = busy_reg;
    done_next      = 1'b0;
    quotient_next  = quotient_reg;
    remainder_next = remainder_reg;
    div_zero_next  = div_zero_reg;
    ovf_next       = ovf_reg;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          dq_next       = dividend_mag;
          vmag_next     = divisor_mag;
          sign_q_next   = dividend[DW-1] ^ divisor[VW-1];
          sign_r_next   = dividend[DW-1];
          dz_next       = (divisor == '0);
          prem_next     = '0;
          cnt_next      = CW'(DW);
          busy_next     = 1'b1;
          div_zero_next = 1'b0;
          ovf_next      = 1'b0;
          state_next    = (divisor == '0) ? ST_FIN : ST_RUN;
        end
      end
      ST_RUN: begin
        prem_next = step_rem;
        dq_next   = {dq_reg[DW-2:0], step_q};
        cnt_next  = cnt_reg - 1'b1;
        if (cnt_reg == CW'(1)) state_next = ST_FIN;
      end
      ST_FIN: begin
        done_next  = 1'b1;
        busy_next  = 1'b0;
        state_next = ST_IDLE;
        if (dz_reg) begin
          quotient_next  = '0;
          remainder_next = '0;
          div_zero_next  = 1'b1;
        end else begin
          quotient_next  = sign_q_reg ? (~dq_reg + 1'b1) : dq_reg;
          remainder_next = sign_r_reg ? (~prem_reg[VW-1:0] + 1'b1) : prem_reg[VW-1:0];
          // A positive result with magnitude 2^(DW-1) cannot be represented;
          // the negated form wraps back to the same bit pattern.
          ovf_next       = ~sign_q_reg & dq_reg[DW-1];
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign quotient  = quotient_reg;
  assign remainder = remainder_reg;
  assign div_zero  = div_zero_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_booth_seq_divider.sv
module tb_booth_seq_divider;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic       busy, done, div_zero, ovf;
  logic [7:0] quotient;
  logic [3:0] remainder;

  int check_cnt = 0;
  int pass_cnt  = 0;

  always #5 clk = ~clk;

  booth_seq_divider dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .ovf       (ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one division and check results, flags and latency. Latency is the
  // number of rising edges after the start-sampling edge until done is seen.
  task automatic run_div(input string tag, input logic [7:0] a, input logic [3:0] b,
                         input logic [7:0] eq, input logic [3:0] er,
                         input logic edz, input logic eovf, input int elat);
    int  lat;
    bit  got;
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk);
    #1 start = 1'b0;
    check({tag, ".busy_on"}, 32'(busy), 32'd1);
    lat = 0; got = 0;
    while (!got && lat < 20) begin
      @(posedge clk);
      #1 lat++;
      if (done) got = 1;
    end
    check({tag, ".latency"}, 32'(lat), 32'(elat));
    check({tag, ".busy_off"}, 32'(busy), 32'd0);
    check({tag, ".quotient"}, 32'(quotient), 32'(eq));
    check({tag, ".remainder"}, 32'(remainder), 32'(er));
    check({tag, ".div_zero"}, 32'(div_zero), 32'(edz));
    check({tag, ".ovf"}, 32'(ovf), 32'(eovf));
    @(posedge clk);
    #1 check({tag, ".done_pulse"}, 32'(done), 32'd0);
    $display("txn %s: %0d / %0d -> q=%02h r=%01h dz=%0b ovf=%0b lat=%0d",
             tag, $signed(a), $signed(b), quotient, remainder, div_zero, ovf, lat);
  endtask

  initial begin
    int done_seen;
    logic signed [7:0] prod;
    logic signed [7:0] xe;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.quotient", 32'(quotient), 32'd0);
    check("rst.remainder", 32'(remainder), 32'd0);
    check("rst.flags", 32'({div_zero, ovf}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors (normal latency 9 edges, divide-by-zero 1 edge)
    run_div("p100_d7",   8'd100,  4'd7,  8'h0E, 4'h2, 1'b0, 1'b0, 9);
    run_div("m100_d7",   8'h9C,   4'd7,  8'hF2, 4'hE, 1'b0, 1'b0, 9);
    run_div("p100_dm8",  8'd100,  4'h8,  8'hF4, 4'h4, 1'b0, 1'b0, 9);
    run_div("m128_dm1",  8'h80,   4'hF,  8'h80, 4'h0, 1'b0, 1'b1, 9);
    run_div("m128_d2",   8'h80,   4'd2,  8'hC0, 4'h0, 1'b0, 1'b0, 9);
    run_div("m128_d7",   8'h80,   4'd7,  8'hEE, 4'hE, 1'b0, 1'b0, 9);
    run_div("p127_dm8",  8'd127,  4'h8,  8'hF1, 4'h7, 1'b0, 1'b0, 9);
    run_div("p55_d0",    8'd55,   4'd0,  8'h00, 4'h0, 1'b1, 1'b0, 1);
    run_div("p6_d3",     8'd6,    4'd3,  8'h02, 4'h0, 1'b0, 1'b0, 9);

    // Ignored restart followed by an asynchronous mid-operation reset
    @(negedge clk);
    start = 1'b1; dividend = 8'd100; divisor = 4'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    start = 1'b1; dividend = 8'd9; divisor = 4'd3;
    @(posedge clk);
    #1 start = 1'b0;
    check("abort.busy_hold", 32'(busy), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.quotient", 32'(quotient), 32'd0);
    check("abort.remainder", 32'(remainder), 32'd0);
    done_seen = 0;
    repeat (2) begin
      @(posedge clk);
      #1 if (done) done_seen++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk);
      #1 if (done) done_seen++;
    end
    check("abort.no_done", 32'(done_seen), 32'd0);
    $display("txn abort: reset mid-operation, done pulses seen=%0d", done_seen);
    run_div("p9_d3", 8'd9, 4'd3, 8'h03, 4'h0, 1'b0, 1'b0, 9);

    // Round trip: 4x4 products divided by the multiplier return the multiplicand
    for (int x = -8; x <= 7; x++) begin
      for (int y = -8; y <= 7; y++) begin
        if (y != 0) begin
          prod = 8'(x * y);
          xe   = 8'(x);
          run_div($sformatf("rt_%0d_%0d", x, y), prod, 4'(y), xe, 4'h0, 1'b0, 1'b0, 9);
        end
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
